// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and constants
package cpu_types_pkg;
  typedef enum logic {IDLE, CLEAR} regfile_clr_state_t;
  localparam int NREGS_DEF = 32;
  localparam int AW = $clog2(NREGS_DEF);
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with per-port lookup
module regfile_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD = 2
) (
  input  logic                            CLK,
  input  logic                            clr,
  input  logic                            busy,
  input  logic                            wvalid,
  input  logic [$clog2(NREGS)-1:0]        wsel,
  input  logic                            rvalid,
  input  logic [$clog2(NREGS)-1:0]        resv_sel,
  input  logic [NRD*$clog2(NREGS)-1:0]    rsel,
  output logic [NRD-1:0]                  pend
);
  localparam int AW = $clog2(NREGS);
  logic [NREGS-1:0] bits, wmask, rmask;
  assign wmask = wvalid ? NREGS'(1) << wsel : '0;
  assign rmask = rvalid ? NREGS'(1) << resv_sel : '0;
  // a new reservation beats a retiring write to the same register
  always_ff @(posedge CLK)
    bits <= clr ? '0 : (bits & ~wmask) | rmask;
  genvar k;
  for (k = 0; k < NRD; k++) begin : g_port
    logic [AW-1:0] a;
    assign a = rsel[k*AW +: AW];
    assign pend[k] = !busy && bits[a] && !(wmask[a] && !rmask[a]);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with bypass, pending scoreboard and sequential clear
module regfile_mp
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          clear_req,
  output logic                          busy,
  input  logic                          wen,
  input  logic [$clog2(NREGS)-1:0]      wsel,
  input  logic [DATA_W-1:0]             wdat,
  input  logic [NRD*$clog2(NREGS)-1:0]  rsel,
  output logic [NRD*DATA_W-1:0]         rdat,
  input  logic                          resv_en,
  input  logic [$clog2(NREGS)-1:0]      resv_sel,
  output logic [NRD-1:0]                pend
);
  localparam int AW = $clog2(NREGS);
  regfile_clr_state_t state, state_n;
  logic [AW-1:0] clr_idx;
  logic [DATA_W-1:0] mem [NREGS];
  logic wvalid, rvalid, start;
  assign busy = state == CLEAR;
  assign wvalid = wen && !busy && !(ZERO_REG != 0 && wsel == '0);
  assign rvalid = resv_en && !busy && !(ZERO_REG != 0 && resv_sel == '0);
  assign start = !busy && clear_req;
  always_comb
    state_n = start ? CLEAR : (busy && clr_idx == AW'(NREGS - 1)) ? IDLE : state;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_n;
      clr_idx <= start ? '0 : busy ? clr_idx + AW'(1) : clr_idx;
    end
  end
  // single write port so storage can map onto a RAM
  always_ff @(posedge CLK) begin
    if (busy) mem[clr_idx] <= '0;
    else if (wvalid) mem[wsel] <= wdat;
  end
  genvar k;
  for (k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rsel[k*AW +: AW];
    assign rdat[k*DATA_W +: DATA_W] = (busy || (ZERO_REG != 0 && a == '0)) ? '0 :
                                      (BYPASS != 0 && wvalid && wsel == a) ? wdat : mem[a];
  end
  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD)) u_sb (
    .CLK(CLK),
    .clr(RST || start),
    .busy(busy),
    .wvalid(wvalid),
    .wsel(wsel),
    .rvalid(rvalid),
    .resv_sel(resv_sel),
    .rsel(rsel),
    .pend(pend)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench with a behavioural model checked every cycle on a bypass and a non-bypass instance
module tb_regfile_mp;
  localparam int DW = 32, NR = 32, ND = 3, AW = 5;
  logic CLK = 0, RST = 1, clear_req = 0, wen = 0, resv_en = 0;
  logic [AW-1:0] wsel = '0, resv_sel = '0;
  logic [DW-1:0] wdat = '0;
  logic [ND*AW-1:0] rsel = '0;
  logic busy_a, busy_b;
  logic [ND*DW-1:0] rdat_a, rdat_b;
  logic [ND-1:0] pend_a, pend_b;
  int checks = 0, failures = 0;
  logic [DW-1:0] m_mem [NR];
  logic [NR-1:0] m_pend = '0;
  int m_busy = 0;
  bit started = 0;

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(ND), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .RST(RST), .clear_req(clear_req), .busy(busy_a), .wen(wen), .wsel(wsel),
    .wdat(wdat), .rsel(rsel), .rdat(rdat_a), .resv_en(resv_en), .resv_sel(resv_sel), .pend(pend_a));
  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(ND), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .RST(RST), .clear_req(clear_req), .busy(busy_b), .wen(wen), .wsel(wsel),
    .wdat(wdat), .rsel(rsel), .rdat(rdat_b), .resv_en(resv_en), .resv_sel(resv_sel), .pend(pend_b));

  task automatic chk(string name, logic [ND*DW-1:0] act, logic [ND*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [AW-1:0] port_sel(int k);
    return rsel[k*AW +: AW];
  endfunction

  function automatic bit m_wv();
    return m_busy == 0 && wen && wsel != 0;
  endfunction

  function automatic bit m_rv();
    return m_busy == 0 && resv_en && resv_sel != 0;
  endfunction

  function automatic logic [DW-1:0] exp_rdat(int k, bit byp);
    logic [AW-1:0] s = port_sel(k);
    if (m_busy > 0 || s == 0) return '0;
    if (byp && m_wv() && wsel == s) return wdat;
    return m_mem[s];
  endfunction

  function automatic logic exp_pend(int k);
    logic [AW-1:0] s = port_sel(k);
    if (m_busy > 0) return 1'b0;
    if (m_wv() && wsel == s && !(m_rv() && resv_sel == s)) return 1'b0;
    return m_pend[s];
  endfunction

  // model: clear walks the array one entry per edge; pending bits as a plain set
  always @(posedge CLK) begin
    if (RST) begin
      started = 1;
      m_busy = NR;
      m_pend = '0;
    end else if (m_busy > 0) begin
      m_mem[NR - m_busy] = '0;
      m_busy--;
    end else begin
      if (m_wv()) begin
        m_mem[wsel] = wdat;
        m_pend[wsel] = 1'b0;
      end
      if (m_rv()) m_pend[resv_sel] = 1'b1;
      if (clear_req) begin
        m_busy = NR;
        m_pend = '0;
      end
    end
  end

  always @(negedge CLK) if (started) begin
    chk("busy_a", busy_a, m_busy > 0);
    chk("busy_b", busy_b, m_busy > 0);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("rdat_a[%0d]", k), rdat_a[k*DW +: DW], exp_rdat(k, 1));
      chk($sformatf("rdat_b[%0d]", k), rdat_b[k*DW +: DW], exp_rdat(k, 0));
      chk($sformatf("pend_a[%0d]", k), pend_a[k], exp_pend(k));
      chk($sformatf("pend_b[%0d]", k), pend_b[k], exp_pend(k));
    end
  end

  initial begin
    int cnt;
    wen = 1; wsel = 5; wdat = 32'hDEAD;
    step();
    RST = 0;
    chk("reset_busy", busy_a, 1);
    chk("reset_rdat", rdat_a, '0);
    chk("reset_pend", pend_a, '0);
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    wen = 0;
    chk("busy_len_reset", cnt, 32);
    rsel = {5'd0, 5'd0, 5'd5};
    #2 chk("read5_after_clear", rdat_a[DW-1:0], 32'h0);
    wen = 1; wsel = 3; wdat = 32'h1234; rsel = {5'd0, 5'd0, 5'd3};
    #2 chk("bypass_same_cycle", rdat_a[DW-1:0], 32'h1234);
    chk("nobypass_old", rdat_b[DW-1:0], 32'h0);
    step();
    wen = 0;
    #2 chk("nobypass_next", rdat_b[DW-1:0], 32'h1234);
    wen = 1; wsel = 0; wdat = 32'hFFFFFFFF; rsel = '0; resv_en = 1; resv_sel = 0;
    #2 chk("zero_bypass", rdat_a, '0);
    chk("zero_pend", pend_a, '0);
    step();
    wen = 0; resv_en = 0;
    #2 chk("zero_after", rdat_a, '0);
    chk("zero_pend_after", pend_a, '0);
    resv_en = 1; resv_sel = 7;
    step();
    resv_en = 0; rsel = {5'd0, 5'd7, 5'd0};
    #2 chk("pend_set", pend_a[1], 1);
    wen = 1; wsel = 7; wdat = 32'h77;
    #2 chk("pend_write_cycle", pend_a[1], 0);
    step();
    wen = 0;
    #2 chk("pend_after_write", pend_a[1], 0);
    resv_en = 1; resv_sel = 7;
    step();
    wen = 1; wsel = 7; wdat = 32'h78;
    #2 chk("pend_same_cycle", pend_a[1], 1);
    step();
    wen = 0; resv_en = 0;
    #2 chk("pend_producer_wins", pend_a[1], 1);
    wen = 1; wsel = 4; wdat = 32'hA;
    step();
    wsel = 6; wdat = 32'hB;
    step();
    wen = 0; rsel = {5'd4, 5'd4, 5'd6};
    #2 chk("multiport", rdat_a, {32'hA, 32'hA, 32'hB});
    wen = 1;
    for (int r = 1; r < NR; r++) begin
      wsel = AW'(r); wdat = 32'h101 * r + 1;
      step();
    end
    wen = 0; resv_en = 1; resv_sel = 9; rsel = {5'd31, 5'd0, 5'd9};
    step();
    resv_en = 0;
    #2 chk("fill_pend9", pend_a[0], 1);
    chk("fill_read31", rdat_a[2*DW +: DW], 32'h101 * 31 + 1);
    clear_req = 1;
    step();
    clear_req = 0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 10) RST = 1;
      step();
      RST = 0;
    end
    chk("busy_len_midclear", cnt, 42);
    for (int r = 0; r < NR; r++) begin
      rsel = {AW'(r), AW'(r), AW'(r)};
      #1 chk($sformatf("cleared_%0d", r), rdat_a, '0);
      chk($sformatf("cleared_pend_%0d", r), pend_a, '0);
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
